// File: rtl/disp_pkg.sv
// disp_pkg: shared scan FSM state type and default 50 MHz timing for the display scanner.
package disp_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} scan_state_t;
  localparam int DEF_DWELL_CYCLES = 12500;
  localparam int DEF_BLANK_CYCLES = 250;
endpackage

// File: rtl/scan_timer.sv
// scan_timer: up-counter restarted by load, flags the last cycle of a limit-cycle interval.
module scan_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_limit,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || i_load) r_cnt <= '0;
    else r_cnt <= r_cnt + W'(1);
  end
  assign o_done = r_cnt == i_limit - W'(1);
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexes one BCD-to-7-segment decoder across N_DIGITS common-anode digits.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  lz_suppress,
  input  logic [4*N_DIGITS-1:0] digits_in,
  output logic [3:0]            bcd_sel,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  seg_blank,
  output logic                  frame_tick
);
  localparam int IW = $clog2(N_DIGITS);
  localparam int TW = $clog2((DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES) + 1);
  scan_state_t           r_state, w_state_n;
  logic [IW-1:0]         r_idx, w_idx_n;
  logic [4*N_DIGITS-1:0] r_snap, w_snap_n;
  logic                  r_lz, w_lz_n;
  logic [3:0]            r_bcd;
  logic [N_DIGITS-1:0]   r_an_n, w_supp;
  logic                  r_blank, r_tick;
  logic                  w_done, w_load, w_start, w_z;
  logic [TW-1:0]         w_limit;
  assign w_limit = r_state == ST_GAP ? TW'(BLANK_CYCLES) : TW'(DWELL_CYCLES);
  assign w_load  = r_state == ST_IDLE || w_done;
  scan_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_limit (w_limit),
    .o_done  (w_done)
  );
  // A frame starts from IDLE or after the gap that follows digit 0; only then is a new snapshot taken.
  always_comb begin
    w_start   = en && (r_state == ST_IDLE || (r_state == ST_GAP && w_done && r_idx == '0));
    w_state_n = r_state == ST_IDLE ? (en ? ST_SHOW : ST_IDLE) :
                !w_done ? r_state :
                r_state == ST_SHOW ? ST_GAP : (en ? ST_SHOW : ST_IDLE);
    w_idx_n   = w_start ? IW'(N_DIGITS - 1) :
                (r_state == ST_GAP && w_done && en) ? r_idx - IW'(1) : r_idx;
    w_snap_n  = w_start ? digits_in : r_snap;
    w_lz_n    = w_start ? lz_suppress : r_lz;
    w_supp    = '0;
    w_z       = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      w_z       = w_z && w_snap_n[4*k +: 4] == 4'd0;
      w_supp[k] = w_lz_n && w_z;
    end
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_snap  <= '0;
      r_lz    <= 1'b0;
      r_bcd   <= 4'd0;
      r_an_n  <= '1;
      r_blank <= 1'b1;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_snap  <= w_snap_n;
      r_lz    <= w_lz_n;
      r_bcd   <= w_state_n == ST_SHOW ? w_snap_n[{w_idx_n, 2'b00} +: 4] : r_bcd;
      r_an_n  <= w_state_n == ST_SHOW ? ~(N_DIGITS'(1) << w_idx_n) : '1;
      r_blank <= w_state_n == ST_SHOW ? w_supp[w_idx_n] : 1'b1;
      r_tick  <= r_state == ST_SHOW && w_done && r_idx == '0;
    end
  end
  assign bcd_sel    = r_bcd;
  assign an_n       = r_an_n;
  assign seg_blank  = r_blank;
  assign frame_tick = r_tick;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed and random scan sequences checked against a frame-position model.
module tb_display_scan_ctrl;
  localparam int N = 4, D = 4, B = 2, S = D + B;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, lz_suppress = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  bcd_sel, an_n;
  logic        seg_blank, frame_tick;
  always #5 clk = ~clk;
  display_scan_ctrl #(.N_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .lz_suppress (lz_suppress),
    .digits_in   (digits_in),
    .bcd_sel     (bcd_sel),
    .an_n        (an_n),
    .seg_blank   (seg_blank),
    .frame_tick  (frame_tick)
  );
  int n_assert = 0, n_fail = 0;
  // Model: position m_p within the frame; each digit slot is D lit cycles then B dark cycles.
  bit          m_act = 1'b0;
  int          m_p = 0;
  logic [15:0] m_snap = '0;
  bit          m_lz = 1'b0;
  logic [3:0]  prev_an = 4'hF;
  int          ticks = 0, cyc = 0, last_tick = -1;
  bit          chk_period = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    bit s_rst, s_en, s_lz, show, supp;
    logic [15:0] s_d;
    logic [3:0] e_an;
    int d;
    s_rst = rst; s_en = en; s_lz = lz_suppress; s_d = digits_in;
    @(posedge clk);
    cyc++;
    if (s_rst) m_act = 1'b0;
    else if (!m_act) begin
      if (s_en) begin m_act = 1'b1; m_p = 0; m_snap = s_d; m_lz = s_lz; end
    end else begin
      m_p++;
      if (m_p % S == 0) begin
        if (!s_en) m_act = 1'b0;
        else if (m_p == N * S) begin m_p = 0; m_snap = s_d; m_lz = s_lz; end
      end
    end
    @(negedge clk);
    d    = N - 1 - m_p / S;
    show = m_act && (m_p % S < D);
    supp = m_lz && d != 0 && (m_snap >> (4 * d)) == 0;
    e_an = show ? ~(4'b0001 << d) : 4'hF;
    chk("an_n", an_n, e_an);
    chk("seg_blank", seg_blank, show ? supp : 1'b1);
    chk("frame_tick", frame_tick, m_act && m_p % S == D && d == 0);
    if (show) chk("bcd_sel", bcd_sel, (m_snap >> (4 * d)) & 16'hF);
    chk("one_cold", $countones(~an_n) <= 1, 1);
    if (prev_an != 4'hF && an_n != 4'hF) chk("no_direct_switch", an_n, prev_an);
    prev_an = an_n;
    if (frame_tick) begin
      ticks++;
      if (chk_period && last_tick >= 0) chk("tick_period", cyc - last_tick, N * S);
      last_tick = cyc;
    end
  endtask
  task automatic run_to_digit(input int dig, input string tag);
    int k = 0;
    while (!(m_act && m_p / S == N - 1 - dig && m_p % S < D) && k < 100) begin step(); k++; end
    chk(tag, k < 100, 1);
  endtask
  initial begin
    int tb;
    repeat (2) step();
    chk("rst_bcd", bcd_sel, 4'd0);
    rst = 1'b0;
    step();
    chk("idle_bcd", bcd_sel, 4'd0);
    digits_in = 16'h1234; en = 1'b1; chk_period = 1'b1;
    repeat (52) step();
    chk("two_ticks", ticks, 2);
    chk_period = 1'b0;
    digits_in = 16'h0070; lz_suppress = 1'b1;
    repeat (48) step();
    digits_in = 16'h1234; lz_suppress = 1'b0;
    run_to_digit(3, "reach_digit3");
    run_to_digit(2, "reach_digit2");
    digits_in = 16'h9999;
    repeat (40) step();
    run_to_digit(1, "reach_digit1");
    en = 1'b0; tb = ticks;
    repeat (12) step();
    chk("no_tick_after_stop", ticks, tb);
    chk("stopped_an", an_n, 4'hF);
    en = 1'b1; digits_in = 16'hA0B5;
    run_to_digit(2, "restart_digit2");
    step();
    rst = 1'b1;
    step();
    chk("midrst_bcd", bcd_sel, 4'd0);
    rst = 1'b0;
    repeat (30) step();
    repeat (600) begin
      digits_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) digits_in[15:8] = 8'h00;
      if ($urandom_range(0, 19) == 0) lz_suppress = ~lz_suppress;
      en = $urandom_range(0, 15) != 0;
      rst = $urandom_range(0, 149) == 0;
      step();
    end
    rst = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
